// File: rtl/key_event_queue_pkg.sv
// Shared types and constants for the key event queue: event record, FSM
// state encoding and the keycodes the rest of the design refers to.
package key_evt_pkg;

    // One queued key edge: press=1 for a key going down, 0 for it coming up.
    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } key_evt_t;

    localparam int KEY_EVT_W = $bits(key_evt_t);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REL   = 2'd1,
        S_PRESS = 2'd2
    } kq_state_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Build an event record from its fields.
    function automatic key_evt_t make_evt(input logic press, input logic [7:0] code);
        key_evt_t evt;
        evt.press = press;
        evt.code  = code;
        return evt;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO. The head is visible combinationally
// while the FIFO is non-empty; a push into a full FIFO is accepted only when
// the head is popped in the same cycle, otherwise it is dropped and the
// sticky overflow flag is raised.
module key_evt_fifo
    import key_evt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [KEY_EVT_W-1:0]         push_data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [KEY_EVT_W-1:0]         head_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level_o,
    output logic                         overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    // Small enough to live in distributed RAM, which gives the asynchronous
    // read needed for fall-through behaviour.
    logic [KEY_EVT_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop_i && !empty;
    // A full FIFO still has room when its head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop_ok);

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (push_i && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers; reset empties the FIFO and clears overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o      = !empty;
    assign head_o       = empty ? '0 : mem_q[rd_ptr_q];
    assign full_o       = full;
    assign fill_level_o = count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/key_event_queue.sv
// Turns the raw keycode bus into debounced press/release events. A keycode
// is accepted once it has been sampled STABLE_CYCLES times in a row; each
// accepted change emits a release of the old key and/or a press of the new
// one into an event FIFO read over a valid/ready handshake.
module key_event_queue
    import key_evt_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [7:0]                   keycode,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic                         ev_press,
    output logic [7:0]                   ev_code,
    output logic                         key_held,
    output logic [7:0]                   held_code,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [7:0]       held_code_q;
    logic             key_held_q;
    logic [7:0]       rel_code_q;
    logic [7:0]       prs_code_q;
    kq_state_t        state_q;

    logic                 accept;
    logic                 push;
    key_evt_t             push_evt;
    logic [KEY_EVT_W-1:0] head_w;
    key_evt_t             head_evt;
    logic                 fifo_valid;
    logic                 fifo_full;

    // Stability counter: restart on any change, otherwise count up and hold
    // at the top so an accept deferred by a busy FSM is never lost.
    always_comb begin
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        if (keycode != cand_q) begin
            cand_d     = keycode;
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    // Accept on the edge whose sample completes the run of equal samples, so
    // a change seen first at edge k is accepted at edge k+STABLE_CYCLES-1.
    // keycode equals cand_d here, i.e. the candidate being accepted.
    assign accept = (stab_cnt_d == CNT_MAX) && (keycode != held_code_q) &&
                    (state_q == S_IDLE);

    // Filter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cand_q     <= KEY_NONE;
            stab_cnt_q <= '0;
        end else begin
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Event sequencer: latch the old/new keycodes on accept, then emit the
    // release and/or press on the following cycles, one push per cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            held_code_q <= KEY_NONE;
            key_held_q  <= 1'b0;
            rel_code_q  <= KEY_NONE;
            prs_code_q  <= KEY_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        held_code_q <= keycode;
                        key_held_q  <= (keycode != KEY_NONE);
                        rel_code_q  <= held_code_q;
                        prs_code_q  <= keycode;
                        // Nothing to release when no key was held before.
                        state_q     <= (held_code_q == KEY_NONE) ? S_PRESS : S_REL;
                    end
                end
                S_REL: begin
                    state_q <= (prs_code_q != KEY_NONE) ? S_PRESS : S_IDLE;
                end
                S_PRESS: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Push is decoded straight from the state register, so it is glitch-free.
    assign push = (state_q == S_REL) || (state_q == S_PRESS);

    // Select the event for the current emitting state.
    always_comb begin
        if (state_q == S_REL) begin
            push_evt = make_evt(1'b0, rel_code_q);
        end else begin
            push_evt = make_evt(1'b1, prs_code_q);
        end
    end

    key_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (Clk),
        .rst_ni       (Reset_n),
        .push_i       (push),
        .push_data_i  (push_evt),
        .pop_i        (ev_ready),
        .valid_o      (fifo_valid),
        .head_o       (head_w),
        .full_o       (fifo_full),
        .fill_level_o (fill_level),
        .overflow_o   (overflow)
    );

    assign head_evt  = key_evt_t'(head_w);
    assign ev_valid  = fifo_valid;
    assign ev_press  = head_evt.press;
    assign ev_code   = head_evt.code;
    assign key_held  = key_held_q;
    assign held_code = held_code_q;

    // Full is only needed inside the FIFO; it is kept on the port list for
    // reuse of the FIFO elsewhere.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (STABLE_CYCLES=4, DEPTH=8). Inputs are
// driven on the falling edge, outputs checked on the falling edge.
module tb_key_event_queue;
    import key_evt_pkg::*;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_press;
    logic [7:0] ev_code;
    logic       key_held;
    logic [7:0] held_code;
    logic       overflow;
    logic [3:0] fill_level;

    int checks = 0;
    int errors = 0;

    key_event_queue #(
        .STABLE_CYCLES (4),
        .DEPTH         (8)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_press   (ev_press),
        .ev_code    (ev_code),
        .key_held   (key_held),
        .held_code  (held_code),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance n rising edges and park on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        keycode  = 8'h00;
        ev_ready = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        tick(1);
    endtask

    // Check the head event and pop it with a one-cycle ready pulse.
    task automatic expect_pop(input string tag, input logic press, input logic [7:0] code);
        check_val({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check_val({tag, "_press"}, 32'(ev_press), 32'(press));
        check_val({tag, "_code"},  32'(ev_code),  32'(code));
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
    endtask

    task automatic press_release(input logic [7:0] code);
        keycode = code;
        tick(6);
        keycode = 8'h00;
        tick(6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        logic [8:0] drain_exp [8];

        // ---- 1: reset state and idle bus ----
        Reset_n  = 1'b0;
        keycode  = 8'h00;
        ev_ready = 1'b1;
        #1;
        check_val("t1_rst_valid",    32'(ev_valid),   32'd0);
        check_val("t1_rst_fill",     32'(fill_level), 32'd0);
        check_val("t1_rst_held",     32'(held_code),  32'd0);
        check_val("t1_rst_overflow", 32'(overflow),   32'd0);
        check_val("t1_rst_code",     32'(ev_code),    32'd0);
        tick(2);
        Reset_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ev_valid) vcnt++;
        end
        check_val("t1_no_valid",  32'(vcnt),     32'd0);
        check_val("t1_key_held",  32'(key_held), 32'd0);

        // ---- 2: ENTER press then release, ready held high ----
        keycode = KEY_ENTER;
        tick(4);
        check_val("t2_pre_valid", 32'(ev_valid),  32'd0);
        check_val("t2_held",      32'(held_code), 32'h28);
        check_val("t2_key_held",  32'(key_held),  32'd1);
        tick(1);
        check_val("t2_valid",     32'(ev_valid),   32'd1);
        check_val("t2_press",     32'(ev_press),   32'd1);
        check_val("t2_code",      32'(ev_code),    32'h28);
        check_val("t2_fill",      32'(fill_level), 32'd1);
        tick(1);
        check_val("t2_one_cycle", 32'(ev_valid),   32'd0);
        keycode = 8'h00;
        tick(4);
        check_val("t2r_pre_valid", 32'(ev_valid), 32'd0);
        check_val("t2r_key_held",  32'(key_held), 32'd0);
        tick(1);
        check_val("t2r_valid",    32'(ev_valid), 32'd1);
        check_val("t2r_press",    32'(ev_press), 32'd0);
        check_val("t2r_code",     32'(ev_code),  32'h28);
        tick(1);
        check_val("t2r_one_cycle", 32'(ev_valid), 32'd0);

        // ---- 3: glitch shorter than the filter ----
        keycode = 8'h1A;
        tick(3);
        keycode = 8'h00;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ev_valid) vcnt++;
        end
        check_val("t3_no_event", 32'(vcnt),      32'd0);
        check_val("t3_held",     32'(held_code), 32'd0);

        // ---- 4: direct key-to-key change ----
        ev_ready = 1'b0;
        keycode  = 8'h04;
        tick(6);
        check_val("t4_fill_a", 32'(fill_level), 32'd1);
        keycode = 8'h07;
        tick(4);
        check_val("t4_fill_accept", 32'(fill_level), 32'd1);
        check_val("t4_held",        32'(held_code),  32'h07);
        tick(1);
        check_val("t4_fill_rel",    32'(fill_level), 32'd2);
        tick(1);
        check_val("t4_fill_prs",    32'(fill_level), 32'd3);
        expect_pop("t4_p04", 1'b1, 8'h04);
        expect_pop("t4_r04", 1'b0, 8'h04);
        expect_pop("t4_p07", 1'b1, 8'h07);
        check_val("t4_empty", 32'(fill_level), 32'd0);

        // ---- 5: overflow, push while full with pop, ordered drain ----
        do_reset();
        for (int c = 4; c <= 8; c++) press_release(8'(c));
        check_val("t5_fill_full", 32'(fill_level), 32'd8);
        check_val("t5_overflow",  32'(overflow),   32'd1);
        keycode = 8'h09;
        tick(4);
        check_val("t5_pre_fill",  32'(fill_level), 32'd8);
        check_val("t5_head_press", 32'(ev_press),  32'd1);
        check_val("t5_head_code", 32'(ev_code),    32'h04);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check_val("t5_fill_pushpop", 32'(fill_level), 32'd8);
        check_val("t5_overflow_sticky", 32'(overflow), 32'd1);
        drain_exp = '{9'h004, 9'h105, 9'h005, 9'h106, 9'h006, 9'h107, 9'h007, 9'h109};
        for (int i = 0; i < 8; i++) begin
            expect_pop($sformatf("t5_drain%0d", i), drain_exp[i][8], drain_exp[i][7:0]);
        end
        check_val("t5_empty_fill",  32'(fill_level), 32'd0);
        check_val("t5_empty_valid", 32'(ev_valid),   32'd0);

        // ---- 6: asynchronous reset while emitting with 3 events queued ----
        do_reset();
        keycode = 8'h04;
        tick(6);
        keycode = 8'h00;
        tick(6);
        keycode = 8'h05;
        tick(6);
        check_val("t6_fill3", 32'(fill_level), 32'd3);
        keycode = 8'h06;
        tick(4);
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("t6_rst_valid",    32'(ev_valid),   32'd0);
        check_val("t6_rst_fill",     32'(fill_level), 32'd0);
        check_val("t6_rst_held",     32'(held_code),  32'd0);
        check_val("t6_rst_key_held", 32'(key_held),   32'd0);
        check_val("t6_rst_code",     32'(ev_code),    32'd0);
        keycode = 8'h00;
        tick(1);
        Reset_n = 1'b1;
        tick(6);
        check_val("t6_no_stale", 32'(ev_valid), 32'd0);
        keycode = KEY_ENTER;
        tick(5);
        check_val("t6_fill1", 32'(fill_level), 32'd1);
        expect_pop("t6_p28", 1'b1, KEY_ENTER);
        tick(8);
        check_val("t6_only_one", 32'(ev_valid), 32'd0);
        check_val("t6_held",     32'(held_code), 32'h28);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
